// File: rtl/bus_mem_pkg.sv
// Shared sizes, FSM state encoding and helpers for the bus memory responder.
// Imported by the storage array and the responder top.
package bus_mem_pkg;

    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        NOADDR   = 2'd0,
        ADDR_OK  = 2'd1,
        ADDR_BAD = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// 64x8 storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module bus_mem_array
    import bus_mem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory responder on a multiplexed address/data CPU bus, with a preload
// port, sticky protocol-error flag and saturating access counters.
module bus_mem_responder
    import bus_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Bus_Out,
    input  logic              ALE,
    input  logic              En,
    input  logic              Rw,
    output logic [DATA_W-1:0] Bus_In,
    output logic              rd_valid,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              bus_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       rd_cnt;
    logic [15:0]       wr_cnt;

    logic              rd;
    logic              wr;
    logic              ale_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ok;
    logic              rd_good;
    logic              wr_good;
    logic              err_set;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign rd     = En & Rw;
    assign wr     = En & ~Rw;
    assign ale_ok = (Bus_Out[7:6] == 2'b00);

    // A read issued with ALE uses the address on the bus this cycle.
    assign rd_addr = ALE ? Bus_Out[ADDR_W-1:0] : addr_q;
    assign rd_ok   = ALE ? ale_ok : (state == ADDR_OK);
    assign rd_good = rd & rd_ok;

    // Bus writes lose to ALE, to a missing/bad address and to a preload.
    assign wr_good = wr & ~ALE & (state == ADDR_OK) & ~load_en;
    assign err_set = (rd & ~rd_ok) | (wr & ~wr_good) | (ALE & ~ale_ok);

    always_comb begin
        state_nx = state;
        if (ALE) begin
            state_nx = ale_ok ? ADDR_OK : ADDR_BAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NOADDR;
        end else begin
            state <= state_nx;
        end
    end

    assign mem_we    = ~rst & (load_en | wr_good);
    assign mem_waddr = load_en ? load_addr : addr_q;
    assign mem_wdata = load_en ? load_data : Bus_Out;

    bus_mem_array u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            Bus_In   <= '0;
            rd_valid <= 1'b0;
            bus_err  <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            if (ALE) begin
                addr_q <= Bus_Out[ADDR_W-1:0];
            end
            if (rd_good) begin
                Bus_In   <= mem_rdata;
                rd_valid <= 1'b1;
                rd_cnt   <= sat_inc(rd_cnt);
            end else if (rd | ~Rw) begin
                Bus_In   <= '0;
                rd_valid <= 1'b0;
            end
            if (wr_good) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
            if (err_set) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign rd_count = rd_cnt;
    assign wr_count = wr_cnt;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed and randomized checks of bus_mem_responder against an
// access-level model of the memory, address latch and counters.
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  Bus_Out = '0;
    logic        ALE = 1'b0;
    logic        En = 1'b0;
    logic        Rw = 1'b1;
    logic [7:0]  Bus_In;
    logic        rd_valid;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        bus_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0]  m_mem [64];
    logic [5:0]  m_addr = '0;
    logic        m_ok   = 1'b0;
    logic [7:0]  e_bus  = '0;
    logic        e_rv   = 1'b0;
    logic        e_err  = 1'b0;
    logic [15:0] e_rd   = '0;
    logic [15:0] e_wr   = '0;

    bus_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .Bus_Out   (Bus_Out),
        .ALE       (ALE),
        .En        (En),
        .Rw        (Rw),
        .Bus_In    (Bus_In),
        .rd_valid  (rd_valid),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .bus_err   (bus_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".bus_in"}, {8'h00, Bus_In}, {8'h00, e_bus});
        chk({tag, ".rd_valid"}, {15'd0, rd_valid}, {15'd0, e_rv});
        chk({tag, ".bus_err"}, {15'd0, bus_err}, {15'd0, e_err});
        chk({tag, ".rd_count"}, rd_count, e_rd);
        chk({tag, ".wr_count"}, wr_count, e_wr);
    endtask

    task automatic model_reset();
        m_addr = '0;
        m_ok   = 1'b0;
        e_bus  = '0;
        e_rv   = 1'b0;
        e_err  = 1'b0;
        e_rd   = '0;
        e_wr   = '0;
    endtask

    // One bus cycle: drive after the falling edge, predict, check after rise.
    task automatic step(input string tag, input logic ale, input logic en,
                        input logic rw, input logic [7:0] bo,
                        input logic le, input logic [5:0] la,
                        input logic [7:0] ld);
        logic [5:0] ea;
        logic       eok;
        @(negedge clk);
        ALE = ale; En = en; Rw = rw; Bus_Out = bo;
        load_en = le; load_addr = la; load_data = ld;
        ea  = ale ? bo[5:0] : m_addr;
        eok = ale ? (bo[7:6] == 2'b00) : m_ok;
        if (en && rw) begin
            if (eok) begin
                e_bus = m_mem[ea];
                e_rv  = 1'b1;
                if (e_rd != 16'hFFFF) e_rd = e_rd + 16'd1;
            end else begin
                e_bus = 8'h00;
                e_rv  = 1'b0;
                e_err = 1'b1;
            end
        end else if (!rw) begin
            e_bus = 8'h00;
            e_rv  = 1'b0;
        end
        if (en && !rw) begin
            if (ale || !m_ok || le) begin
                e_err = 1'b1;
            end else begin
                m_mem[m_addr] = bo;
                if (e_wr != 16'hFFFF) e_wr = e_wr + 16'd1;
            end
        end
        if (le) m_mem[la] = ld;
        if (ale) begin
            m_addr = bo[5:0];
            m_ok   = (bo[7:6] == 2'b00);
            if (!m_ok) e_err = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'($urandom);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 64; i++)
            step("preload", 0, 0, 1, 8'h00, 1, 6'(i),
                 (i == 7) ? 8'hFD : m_mem[i]);

        step("a7", 1, 0, 1, 8'd7, 0, 0, 0);
        step("rd7", 0, 1, 1, 8'h00, 0, 0, 0);
        chk("rd7_data", {8'h00, Bus_In}, 16'h00FD);
        chk("rd7_cnt", rd_count, 16'd1);
        step("hold", 0, 0, 1, 8'h00, 0, 0, 0);
        chk("hold_data", {8'h00, Bus_In}, 16'h00FD);

        step("a12", 1, 0, 1, 8'd12, 0, 0, 0);
        step("wr12", 0, 1, 0, 8'h07, 0, 0, 0);
        step("rd12", 0, 1, 1, 8'h00, 0, 0, 0);
        chk("rd12_data", {8'h00, Bus_In}, 16'h0007);
        chk("wr12_cnt", wr_count, 16'd1);
        chk("wr12_err", {15'd0, bus_err}, 16'd0);

        step("bypass", 1, 1, 1, 8'd20, 0, 0, 0);
        step("rbw", 1, 1, 1, 8'd9, 1, 6'd9, 8'h3C);
        step("rbw_new", 0, 1, 1, 8'h00, 0, 0, 0);
        chk("rbw_new_data", {8'h00, Bus_In}, 16'h003C);

        step("a40", 1, 0, 1, 8'h40, 0, 0, 0);
        chk("a40_err", {15'd0, bus_err}, 16'd1);
        step("wr_bad", 0, 1, 0, 8'h55, 0, 0, 0);
        step("rd_bad", 0, 1, 1, 8'h00, 0, 0, 0);
        chk("rd_bad_data", {8'h00, Bus_In}, 16'h0000);
        chk("rd_bad_valid", {15'd0, rd_valid}, 16'd0);
        step("rd0", 1, 1, 1, 8'h00, 0, 0, 0);

        step("a3", 1, 0, 1, 8'd3, 0, 0, 0);
        step("ld_vs_wr", 0, 1, 0, 8'h11, 1, 6'd3, 8'hAA);
        step("rd3", 0, 1, 1, 8'h00, 0, 0, 0);
        chk("rd3_data", {8'h00, Bus_In}, 16'h00AA);

        step("a5", 1, 0, 1, 8'd5, 0, 0, 0);
        step("rd5", 0, 1, 1, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        En = 1'b1; Rw = 1'b0; ALE = 1'b0; Bus_Out = 8'hEE; load_en = 1'b0;
        model_reset();
        #1;
        chk_all("rst_async");
        @(posedge clk);
        #1;
        chk_all("rst_edge");
        @(negedge clk);
        rst = 1'b0;
        En = 1'b0; Rw = 1'b1;
        step("rd_noaddr", 0, 1, 1, 8'h00, 0, 0, 0);
        step("rd5_kept", 1, 1, 1, 8'd5, 0, 0, 0);

        En = 1'b0; Rw = 1'b1; ALE = 1'b0; load_en = 1'b0;
        force dut.rd_cnt = 16'hFFFE;
        #1;
        release dut.rd_cnt;
        e_rd = 16'hFFFE;
        for (int i = 0; i < 3; i++) step("sat", 0, 1, 1, 8'h00, 0, 0, 0);
        chk("sat_cnt", rd_count, 16'hFFFF);

        for (int i = 0; i < 400; i++) begin
            logic ale, en, rw, le;
            ale = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 3) != 0);
            rw  = 1'($urandom);
            le  = ($urandom_range(0, 7) == 0);
            b   = 8'($urandom);
            if (ale && $urandom_range(0, 4) != 0) b[7:6] = 2'b00;
            step("rand", ale, en, rw, b, le, 6'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
